// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants for the prescaled up/down counter: overflow modes and legal width range.
package prescaled_updown_counter_pkg;
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 32;
endpackage

// File: rtl/prescaled_updown_counter_tick_divider.sv
// Enable-gated prescaler: raises adv on the last enabled cycle of each 2**PRESCALE_BITS period.
module tick_divider #(
  parameter int PRESCALE_BITS = 2
) (
  input  logic clock,
  input  logic reset_,
  input  logic enable,
  input  logic clear,
  output logic adv
);
  // Keep at least one register bit so the zero-prescale build needs no special port handling.
  localparam int PW = (PRESCALE_BITS == 0) ? 1 : PRESCALE_BITS;

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign adv = enable && ((PRESCALE_BITS == 0) || (&pre_q));
endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down counter advanced by a prescaled enable, with wrap or saturate overflow handling.
module prescaled_updown_counter
  import prescaled_updown_counter_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int PRESCALE_BITS = 2,
  parameter int SATURATE      = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             overflow,
  output logic             at_max,
  output logic             at_min
);
  logic             adv;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tick_q, tick_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   ext;

  tick_divider #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_tick_divider (
    .clock  (clock),
    .reset_ (reset_),
    .enable (enable),
    .clear  (load),
    .adv    (adv)
  );

  // The extra top bit is the carry on add and the borrow on subtract.
  always_comb begin
    counter_d  = counter_q;
    tick_d     = 1'b0;
    overflow_d = 1'b0;
    ext        = up ? ({1'b0, counter_q} + {1'b0, step})
                    : ({1'b0, counter_q} - {1'b0, step});
    if (load) begin
      counter_d = load_value;
    end else if (adv) begin
      tick_d     = 1'b1;
      overflow_d = ext[WIDTH];
      if ((SATURATE == MODE_SATURATE) && ext[WIDTH]) begin
        counter_d = up ? '1 : '0;
      end else begin
        counter_d = ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      counter_q  <= '0;
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      tick_q     <= tick_d;
      overflow_q <= overflow_d;
    end
  end

  assign counter  = counter_q;
  assign tick     = tick_q;
  assign overflow = overflow_q;
  assign at_max   = &counter_q;
  assign at_min   = ~|counter_q;
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Three 4-bit counter variants driven in lockstep and checked against an arithmetic reference model.
module tb_prescaled_updown_counter;
  localparam int MP[3] = '{2, 0, 0};
  localparam int MS[3] = '{0, 1, 0};

  logic       clock = 1'b0;
  logic       reset_;
  logic       enable, up, load;
  logic [3:0] step, load_value;
  logic [3:0] cnt_o [3];
  logic [2:0] tick_o, ovf_o, amax_o, amin_o;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt[3], m_ph[3], m_tick[3], m_ovf[3];

  always #5 clock = ~clock;

  prescaled_updown_counter #(.WIDTH(4), .PRESCALE_BITS(2), .SATURATE(0)) dut_a (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .counter(cnt_o[0]), .tick(tick_o[0]),
    .overflow(ovf_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));

  prescaled_updown_counter #(.WIDTH(4), .PRESCALE_BITS(0), .SATURATE(1)) dut_b (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .counter(cnt_o[1]), .tick(tick_o[1]),
    .overflow(ovf_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));

  prescaled_updown_counter #(.WIDTH(4), .PRESCALE_BITS(0), .SATURATE(0)) dut_c (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
    .load(load), .load_value(load_value), .counter(cnt_o[2]), .tick(tick_o[2]),
    .overflow(ovf_o[2]), .at_max(amax_o[2]), .at_min(amin_o[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_tick[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Reference: count enabled cycles per period, then add/subtract with plain integer arithmetic.
  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      int span, v;
      bit fire;
      span = 1 << MP[i];
      m_tick[i] = 0;
      m_ovf[i]  = 0;
      if (load) begin
        m_cnt[i] = int'(load_value);
        m_ph[i]  = 0;
      end else if (enable) begin
        fire    = (m_ph[i] == span - 1);
        m_ph[i] = (m_ph[i] + 1) % span;
        if (fire) begin
          v = up ? m_cnt[i] + int'(step) : m_cnt[i] - int'(step);
          m_tick[i] = 1;
          if (v > 15) begin
            m_ovf[i] = 1;
            v = (MS[i] == 1) ? 15 : v - 16;
          end else if (v < 0) begin
            m_ovf[i] = 1;
            v = (MS[i] == 1) ? 0 : v + 16;
          end
          m_cnt[i] = v;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cnt%0d", i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("tick%0d", i), int'(tick_o[i]), m_tick[i]);
      chk($sformatf("ovf%0d", i), int'(ovf_o[i]), m_ovf[i]);
      chk($sformatf("at_max%0d", i), int'(amax_o[i]), (m_cnt[i] == 15) ? 1 : 0);
      chk($sformatf("at_min%0d", i), int'(amin_o[i]), (m_cnt[i] == 0) ? 1 : 0);
    end
  endtask

  task automatic cyc(input bit en, input bit u, input int st, input bit ld, input int lv);
    enable     = en;
    up         = u;
    step       = 4'(st);
    load       = ld;
    load_value = 4'(lv);
    model_clock();
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    reset_ = 1'b0;
    enable = 1'b0; up = 1'b1; step = '0; load = 1'b0; load_value = '0;
    model_reset();
    #1;
    check_all();
    #11;
    reset_ = 1'b1;

    // Free-running count on the /4 wrap instance.
    for (int k = 0; k < 64; k++) begin
      cyc(1, 1, 1, 0, 0);
      chk("r33_tick", int'(tick_o[0]), (k % 4 == 3) ? 1 : 0);
      chk("r33_cnt", int'(cnt_o[0]), ((k + 1) / 4) % 16);
      chk("r33_ovf", int'(ovf_o[0]), (k == 63) ? 1 : 0);
    end

    // Saturating clamp.
    cyc(0, 1, 3, 1, 14);
    cyc(1, 1, 3, 0, 0);
    chk("r34_cnt1", int'(cnt_o[1]), 15);
    chk("r34_ovf1", int'(ovf_o[1]), 1);
    cyc(1, 1, 3, 0, 0);
    chk("r34_cnt2", int'(cnt_o[1]), 15);
    chk("r34_ovf2", int'(ovf_o[1]), 1);
    cyc(1, 0, 5, 0, 0);
    chk("r34_cnt3", int'(cnt_o[1]), 10);
    chk("r34_ovf3", int'(ovf_o[1]), 0);

    // Wrap on borrow.
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 2, 0, 0);
    chk("r35_cnt", int'(cnt_o[2]), 15);
    chk("r35_ovf", int'(ovf_o[2]), 1);

    // Load coinciding with an advance, then a full fresh prescale period.
    for (int k = 0; k < 4 && m_ph[0] != 3; k++) cyc(1, 1, 1, 0, 0);
    chk("r36_phase", m_ph[0], 3);
    cyc(1, 1, 1, 1, 9);
    chk("r36_cnt", int'(cnt_o[0]), 9);
    chk("r36_tick", int'(tick_o[0]), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 0, 0);
      chk("r36_wait", int'(tick_o[0]), 0);
    end
    cyc(1, 1, 1, 0, 0);
    chk("r36_adv", int'(tick_o[0]), 1);
    chk("r36_cnt2", int'(cnt_o[0]), 10);

    // Enable dropped mid-period delays the update by the same number of cycles.
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0);
      chk("r37_hold", int'(cnt_o[0]), 10);
      chk("r37_tick", int'(tick_o[0]), 0);
    end
    cyc(1, 1, 1, 0, 0);
    chk("r37_pre", int'(tick_o[0]), 0);
    cyc(1, 1, 1, 0, 0);
    chk("r37_adv", int'(tick_o[0]), 1);
    chk("r37_cnt", int'(cnt_o[0]), 11);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      bit ld, en;
      int st;
      ld = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      cyc(en, 1'($urandom), st, ld, int'($urandom_range(0, 15)));
    end

    // Asynchronous reset between edges.
    cyc(0, 1, 1, 1, 7);
    cyc(1, 1, 1, 0, 0);
    #2;
    reset_ = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("r38_cnt", int'(cnt_o[i]), 0);
      chk("r38_tick", int'(tick_o[i]), 0);
      chk("r38_ovf", int'(ovf_o[i]), 0);
    end
    @(posedge clock);
    #1;
    check_all();
    reset_ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 2, 0, 0);
      chk("r28_tick", int'(tick_o[0]), (k % 4 == 3) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
